// File: rtl/axis_emu_mp.sv
// ---------------------------------------------------------------------------
// axis_emu_mp
//
// Multi-player analog-axis emulator for the 5200 POT X/Y joystick inputs.
// For each player the axis source is one of:
//   PASS  - the USB analog stick value is forwarded unchanged
//   MOUSE - a saturating accumulator of clamped PS/2 mouse deltas
//   DPAD  - a saturating ramp driven by the D-pad, stepped once per tick
// Any non-zero stick value, or halt, drops the player back to PASS and
// clears that player's accumulators.
//
// Ports
//   CLK_VIDEO     clock
//   reset         synchronous, active-high
//   mouse_stb     toggles once per new mouse packet
//   mouse_dx/dy   signed 9-bit mouse deltas
//   mouse_btn     mouse buttons {R,L}
//   mouse_player  player receiving mouse events (values >= PLAYERS ignored)
//   invert_y      1 = subtract Y delta
//   halt          forces every player to PASS
//   tick          one-cycle ramp strobe (once per frame)
//   analog_in     stick values, {Y,X} per player, player 0 at the LSBs
//   dpad          {U,D,L,R} per player
//   axis_out      registered emulated {Y,X} per player
//   btn_out       mouse buttons for a player in MOUSE mode, else 0
//   emu_active    1 while the player is in MOUSE or DPAD mode
//
// Build option
//   AXIS_AUTOCENTER_EN - when defined, an axis with no input on a tick
//   decays toward 0 by RAMP_STEP (clamping exactly at 0). When undefined,
//   idle axes hold their value.
// ---------------------------------------------------------------------------
module axis_emu_mp #(
    parameter int PLAYERS   = 2,
    parameter int AXIS_W    = 8,
    parameter int STEP_MAX  = 10,
    parameter int RAMP_STEP = 4
) (
    input  logic                          CLK_VIDEO,
    input  logic                          reset,
    input  logic                          mouse_stb,
    input  logic [8:0]                    mouse_dx,
    input  logic [8:0]                    mouse_dy,
    input  logic [1:0]                    mouse_btn,
    input  logic [1:0]                    mouse_player,
    input  logic                          invert_y,
    input  logic                          halt,
    input  logic                          tick,
    input  logic [PLAYERS*2*AXIS_W-1:0]   analog_in,
    input  logic [PLAYERS*4-1:0]          dpad,
    output logic [PLAYERS*2*AXIS_W-1:0]   axis_out,
    output logic [PLAYERS*2-1:0]          btn_out,
    output logic [PLAYERS-1:0]            emu_active
);

    // Two guard bits let a sum overflow the axis range before saturation.
    localparam int ACC_W = AXIS_W + 2;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_MOUSE = 2'd1,
        MODE_DPAD  = 2'd2
    } mode_t;

    localparam logic signed [ACC_W-1:0] SAT_HI  = ACC_W'((1 <<< (AXIS_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO  = ACC_W'(-(1 <<< (AXIS_W-1)));
    localparam logic signed [ACC_W-1:0] RAMP_V  = ACC_W'(RAMP_STEP);
    localparam logic signed [8:0]       STEP_HI = 9'(STEP_MAX);
    localparam logic signed [8:0]       STEP_LO = 9'(-STEP_MAX);

    // Clamp a raw 9-bit mouse delta to +/-STEP_MAX, then widen.
    function automatic logic signed [ACC_W-1:0] clamp_delta(input logic signed [8:0] d);
        logic signed [8:0] c;
        if (d > STEP_HI) begin
            c = STEP_HI;
        end else if (d < STEP_LO) begin
            c = STEP_LO;
        end else begin
            c = d;
        end
        return ACC_W'(c);
    endfunction

    // Add at ACC_W bits and saturate back into the signed axis range.
    function automatic logic signed [AXIS_W-1:0] sat_add(input logic signed [AXIS_W-1:0] a,
                                                         input logic signed [ACC_W-1:0]  b);
        logic signed [ACC_W-1:0] s;
        s = ACC_W'(a) + b;
        if (s > SAT_HI) begin
            s = SAT_HI;
        end else if (s < SAT_LO) begin
            s = SAT_LO;
        end
        return s[AXIS_W-1:0];
    endfunction

`ifdef AXIS_AUTOCENTER_EN
    // Step toward zero; anything closer than one step lands exactly on 0.
    function automatic logic signed [AXIS_W-1:0] decay(input logic signed [AXIS_W-1:0] a);
        logic signed [ACC_W-1:0] w;
        w = ACC_W'(a);
        if (w >= RAMP_V) begin
            w = w - RAMP_V;
        end else if (w <= -RAMP_V) begin
            w = w + RAMP_V;
        end else begin
            w = '0;
        end
        return w[AXIS_W-1:0];
    endfunction
`endif

    // One D-pad axis on a tick: opposing or absent directions mean no input.
    function automatic logic signed [AXIS_W-1:0] ramp_axis(input logic signed [AXIS_W-1:0] a,
                                                           input logic pos,
                                                           input logic neg);
        if (pos && !neg) begin
            return sat_add(a, RAMP_V);
        end
        if (neg && !pos) begin
            return sat_add(a, -RAMP_V);
        end
`ifdef AXIS_AUTOCENTER_EN
        return decay(a);
`else
        return a;
`endif
    endfunction

    // Mouse packet detection: any change of the strobe level is one event.
    // The delayed copy keeps tracking through reset so a strobe left high
    // during reset does not produce a spurious event afterwards.
    logic                    stb_d_reg;
    logic                    mouse_evt;
    logic signed [ACC_W-1:0] dx_c;
    logic signed [ACC_W-1:0] dy_c;
    logic signed [ACC_W-1:0] dy_eff;

    always_ff @(posedge CLK_VIDEO) begin
        stb_d_reg <= mouse_stb;
    end

    assign mouse_evt = mouse_stb ^ stb_d_reg;
    assign dx_c      = clamp_delta(mouse_dx);
    assign dy_c      = clamp_delta(mouse_dy);
    assign dy_eff    = invert_y ? -dy_c : dy_c;

    for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_player
        localparam logic [1:0] IDX = 2'(gi);

        mode_t                    mode_reg;
        mode_t                    mode_next;
        logic signed [AXIS_W-1:0] acc_x_reg;
        logic signed [AXIS_W-1:0] acc_x_next;
        logic signed [AXIS_W-1:0] acc_y_reg;
        logic signed [AXIS_W-1:0] acc_y_next;
`ifdef AXIS_AUTOCENTER_EN
        // Set by a mouse event, cleared by a tick: "had input since last tick".
        logic                     seen_reg;
        logic                     seen_next;
`endif
        logic [AXIS_W-1:0]        ana_x;
        logic [AXIS_W-1:0]        ana_y;
        logic [3:0]               pad;
        logic                     clr;
        logic                     mevt;
        logic [AXIS_W-1:0]        sel_x;
        logic [AXIS_W-1:0]        sel_y;
        logic [1:0]               sel_btn;
        logic                     sel_act;
        logic [2*AXIS_W-1:0]      axis_q_reg;
        logic [1:0]               btn_q_reg;
        logic                     act_q_reg;

        assign ana_x = analog_in[gi*2*AXIS_W +: AXIS_W];
        assign ana_y = analog_in[gi*2*AXIS_W + AXIS_W +: AXIS_W];
        assign pad   = dpad[gi*4 +: 4];
        assign clr   = (ana_x != '0) || (ana_y != '0) || halt;
        assign mevt  = mouse_evt && (mouse_player == IDX);

        // State register
        always_ff @(posedge CLK_VIDEO) begin
            if (reset) begin
                mode_reg  <= MODE_PASS;
                acc_x_reg <= '0;
                acc_y_reg <= '0;
`ifdef AXIS_AUTOCENTER_EN
                seen_reg  <= 1'b0;
`endif
            end else begin
                mode_reg  <= mode_next;
                acc_x_reg <= acc_x_next;
                acc_y_reg <= acc_y_next;
`ifdef AXIS_AUTOCENTER_EN
                seen_reg  <= seen_next;
`endif
            end
        end

        // Next-state: return to PASS beats a mouse event, which beats a tick.
        always_comb begin
            mode_next = mode_reg;
            if (clr) begin
                mode_next = MODE_PASS;
            end else if (mevt) begin
                mode_next = MODE_MOUSE;
            end else if (tick && (pad != 4'd0)) begin
                mode_next = MODE_DPAD;
            end
        end

        // Accumulator update, same priority order as the mode transitions.
        always_comb begin
            acc_x_next = acc_x_reg;
            acc_y_next = acc_y_reg;
`ifdef AXIS_AUTOCENTER_EN
            seen_next  = seen_reg;
`endif
            if (clr) begin
                acc_x_next = '0;
                acc_y_next = '0;
`ifdef AXIS_AUTOCENTER_EN
                seen_next  = 1'b0;
`endif
            end else if (mevt) begin
                acc_x_next = sat_add(acc_x_reg, dx_c);
                acc_y_next = sat_add(acc_y_reg, dy_eff);
`ifdef AXIS_AUTOCENTER_EN
                seen_next  = 1'b1;
`endif
            end else if (tick) begin
`ifdef AXIS_AUTOCENTER_EN
                seen_next = 1'b0;
`endif
                // pad = {U,D,L,R}: X grows with R, Y grows with D.
                if (mode_next == MODE_DPAD) begin
                    acc_x_next = ramp_axis(acc_x_reg, pad[0], pad[1]);
                    acc_y_next = ramp_axis(acc_y_reg, pad[2], pad[3]);
                end
`ifdef AXIS_AUTOCENTER_EN
                else if ((mode_next == MODE_MOUSE) && !seen_reg) begin
                    acc_x_next = decay(acc_x_reg);
                    acc_y_next = decay(acc_y_reg);
                end
`endif
            end
        end

        // Output selection from the current mode.
        always_comb begin
            sel_x   = ana_x;
            sel_y   = ana_y;
            sel_btn = 2'b00;
            sel_act = 1'b0;
            case (mode_reg)
                MODE_MOUSE: begin
                    sel_x   = acc_x_reg;
                    sel_y   = acc_y_reg;
                    sel_btn = mouse_btn;
                    sel_act = 1'b1;
                end
                MODE_DPAD: begin
                    sel_x   = acc_x_reg;
                    sel_y   = acc_y_reg;
                    sel_act = 1'b1;
                end
                default: begin
                end
            endcase
        end

        always_ff @(posedge CLK_VIDEO) begin
            if (reset) begin
                axis_q_reg <= '0;
                btn_q_reg  <= 2'b00;
                act_q_reg  <= 1'b0;
            end else begin
                axis_q_reg <= {sel_y, sel_x};
                btn_q_reg  <= sel_btn;
                act_q_reg  <= sel_act;
            end
        end

        assign axis_out[gi*2*AXIS_W +: 2*AXIS_W] = axis_q_reg;
        assign btn_out[gi*2 +: 2]                = btn_q_reg;
        assign emu_active[gi]                    = act_q_reg;
    end

endmodule
